// File: rtl/imm_encoder.sv
// RV32I instruction packer: fields + signed immediate -> instruction word, 2-stage valid/ready pipe.
// Optional: define IMM_ENC_ERRCNT_EN to add a saturating err_cnt output.
module imm_encoder #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err
`ifdef IMM_ENC_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [2:0] {
        FMT_U      = 3'd0,
        FMT_J      = 3'd1,
        FMT_I      = 3'd2,
        FMT_S      = 3'd3,
        FMT_B      = 3'd4,
        FMT_ISHIFT = 3'd5,
        FMT_BAD6   = 3'd6,
        FMT_BAD7   = 3'd7
    } fmt_e;

    fmt_e        in_fmt_e;
    logic        imm_ok;

    logic        s1_valid;
    fmt_e        s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic        s1_f7b5;
    logic [31:0] s1_imm;
    logic        s1_ok;

    logic        s2_valid;
    logic        s1_adv;
    logic        s2_adv;
    logic [31:0] enc;

    // Only funct7[5] matters (ISHIFT); the rest is intentionally dropped.
    logic        unused_f7;
    assign unused_f7 = ^{in_funct7[6], in_funct7[4:0]};

    assign in_fmt_e  = fmt_e'(in_fmt);
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        imm_ok = 1'b0;
        case (in_fmt_e)
            FMT_U:      imm_ok = (in_imm[11:0] == '0);
            FMT_J:      imm_ok = ($signed(in_imm) >= -32'sd1048576) &&
                                 ($signed(in_imm) <=  32'sd1048574) && !in_imm[0];
            FMT_I,
            FMT_S:      imm_ok = ($signed(in_imm) >= -32'sd2048) &&
                                 ($signed(in_imm) <=  32'sd2047);
            FMT_B:      imm_ok = ($signed(in_imm) >= -32'sd4096) &&
                                 ($signed(in_imm) <=  32'sd4094) && !in_imm[0];
            FMT_ISHIFT: imm_ok = (in_imm <= 32'd31);
            default:    imm_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_U;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_f3     <= '0;
            s1_f7b5   <= 1'b0;
            s1_imm    <= '0;
            s1_ok     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= in_fmt_e;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_f3     <= in_funct3;
                s1_f7b5   <= in_funct7[5];
                s1_imm    <= in_imm;
                s1_ok     <= imm_ok;
            end
        end
    end

    always_comb begin
        enc = NOP_INST;
        case (s1_fmt)
            FMT_U:      enc = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J:      enc = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                               s1_rd, s1_opcode};
            FMT_I:      enc = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_opcode};
            FMT_S:      enc = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_opcode};
            FMT_B:      enc = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                               s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_ISHIFT: enc = {1'b0, s1_f7b5, 5'b0, s1_imm[4:0], s1_rs1, s1_f3,
                               s1_rd, s1_opcode};
            default:    enc = NOP_INST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_inst <= '0;
            out_err  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= s1_ok ? enc : NOP_INST;
                out_err  <= !s1_ok;
            end
        end
    end

`ifdef IMM_ENC_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (s2_valid && out_ready && out_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, stall, reset flush, randomized model check.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
`ifdef IMM_ENC_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    imm_encoder #(.NOP_INST(32'h00000013)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err)
`ifdef IMM_ENC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          naccept = 0;
    bit          held = 0;
    logic [31:0] held_inst;
    logic        held_err;
    bit          rnd_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: field positions built with shifts/masks straight from the ISA layout.
    function automatic logic [32:0] model(input logic [2:0] fmt, input logic [6:0] opc,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] imm);
        longint      v;
        bit          ok;
        logic [31:0] w;
        logic [31:0] base_rd;
        logic [31:0] base_i;
        v = longint'($signed(imm));
        base_rd = (32'(rd) << 7) | 32'(opc);
        base_i  = (32'(rs1) << 15) | (32'(f3) << 12);
        ok = 0;
        w  = '0;
        case (fmt)
            3'd0: begin
                ok = (imm % 4096) == 0;
                w  = ((imm >> 12) << 12) | base_rd;
            end
            3'd1: begin
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
                     (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | base_rd;
            end
            3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = ((imm & 4095) << 20) | base_i | base_rd;
            end
            3'd3: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (((imm >> 5) & 127) << 25) | (32'(rs2) << 20) | base_i |
                     ((imm & 31) << 7) | 32'(opc);
            end
            3'd4: begin
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
                     (32'(rs2) << 20) | base_i | (((imm >> 1) & 15) << 8) |
                     (((imm >> 11) & 1) << 7) | 32'(opc);
            end
            3'd5: begin
                ok = (v >= 0) && (v <= 31);
                w  = (32'(f7[5]) << 30) | ((imm & 31) << 20) | base_i | base_rd;
            end
            default: ok = 0;
        endcase
        return {!ok, ok ? w : 32'h00000013};
    endfunction

    task automatic send(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] e_inst, input logic e_err, input bit lat);
        int   waited = 0;
        bit   done = 0;
        exp_t e;
        in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.inst = e_inst; e.err = e_err; e.acc_cyc = cyc; e.chk_lat = lat;
                sb.push_back(e);
                naccept++;
                done = 1;
            end else if (++waited > 500) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual=in_ready_low required=accept");
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [2:0] fmt, input logic [31:0] imm);
        logic [6:0]  opc = 7'($urandom);
        logic [4:0]  rd  = 5'($urandom);
        logic [4:0]  rs1 = 5'($urandom);
        logic [4:0]  rs2 = 5'($urandom);
        logic [2:0]  f3  = 3'($urandom);
        logic [6:0]  f7  = 7'($urandom);
        logic [32:0] m;
        m = model(fmt, opc, rd, rs1, rs2, f3, f7, imm);
        send(fmt, opc, rd, rs1, rs2, f3, f7, imm, m[31:0], m[32], 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else if (out_valid) begin
            if (held) begin
                chk("hold_inst", out_inst, held_inst);
                chk("hold_err", 32'(out_err), 32'(held_err));
            end
            if (out_ready) begin
                held = 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", out_inst);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks--;
                    chk("out_inst", out_inst, e.inst);
                    chk("out_err", 32'(out_err), 32'(e.err));
                    if (e.chk_lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
                end
            end else begin
                held = 1;
                held_inst = out_inst;
                held_err = out_err;
            end
        end else begin
            held = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int edges[10] = '{-1048576, 1048574, -2048, 2047, -4096, 4094, 0, 31, 4096, 1048576};

    initial begin
        int accepted_at_stall;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_inst", out_inst, 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors; unused field inputs are deliberately nonzero.
        send(3'd2, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7f, 32'hFFFFFFFF, 32'hFFF00093, 0, 1);
        send(3'd1, 7'h6F, 5'd1, 5'd9, 5'd9, 3'd7, 7'h7f, 32'd2048, 32'h001000EF, 0, 1);
        send(3'd1, 7'h6F, 5'd1, 5'd9, 5'd9, 3'd7, 7'h7f, 32'd2049, 32'h00000013, 1, 1);
        send(3'd4, 7'h63, 5'd17, 5'd1, 5'd2, 3'd0, 7'h7f, 32'd8, 32'h00208463, 0, 1);
        send(3'd4, 7'h63, 5'd17, 5'd1, 5'd2, 3'd0, 7'h7f, 32'd4096, 32'h00000013, 1, 1);
        send(3'd5, 7'h13, 5'd1, 5'd1, 5'd3, 3'd5, 7'h20, 32'd3, 32'h4030D093, 0, 1);
        send(3'd5, 7'h13, 5'd1, 5'd1, 5'd3, 3'd5, 7'h20, 32'd32, 32'h00000013, 1, 1);
        send(3'd6, 7'h13, 5'd1, 5'd1, 5'd3, 3'd5, 7'h20, 32'd0, 32'h00000013, 1, 1);
        wait_drain();

        // Backpressure: 4 back-to-back requests against 5 stalled cycles.
        naccept = 0;
        accepted_at_stall = -1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(3'd2, 7'h13, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(i * 5),
                         32'((i * 5) << 20) | 32'h00010013 | 32'((i + 1) << 7), 0, 0);
            end
            begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 2) begin
                        chk("stall_in_ready", 32'(in_ready), 32'd0);
                        accepted_at_stall = naccept;
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("stall_accepts", 32'(accepted_at_stall), 32'd2);
        wait_drain();

        // Randomized traffic with random consumer backpressure.
        rnd_on = 1;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    logic [2:0]  fmt;
                    logic [31:0] imm;
                    fmt = 3'($urandom_range(0, 7));
                    case ($urandom_range(0, 5))
                        0: imm = $urandom;
                        1: imm = $urandom_range(0, 40);
                        2: imm = 32'(edges[$urandom_range(0, 9)] + int'($urandom_range(0, 2)) - 1);
                        3: imm = $urandom & 32'hFFFFF000;
                        4: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                        default: imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
                    endcase
                    send_rand(fmt, imm);
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with both stages full: in-flight words must vanish.
        out_ready = 1'b0;
        send(3'd2, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00118193, 0, 0);
        send(3'd2, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00220213, 0, 0);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("post_reset_out_inst", out_inst, 32'd0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("flushed_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
`ifdef IMM_ENC_ERRCNT_EN
        chk("errcnt_reset", 32'(err_cnt), 32'd0);
        for (int n = 0; n < 300; n++)
            send(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h00000013, 1, 0);
        wait_drain();
        chk("errcnt_saturate", 32'(err_cnt), 32'd255);
`endif
        send(3'd0, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 0, 1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
